lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
Receive-side companion to the team's 4-bit Fibonacci LFSR pattern generator (polynomial x^4+x^3+1).
- Consumes the generator's serial bit stream and self-synchronises by loading received bits into a local shift register.
- Predicts each next bit, declares lock after a run of correct predictions, then counts bit errors and drops lock on sustained mismatch.
- Sits at the far end of any link or loopback under test, e.g. lab FSM/LED test paths.

Parameters:
- WIDTH, 4, shift register length.
- TAP_A, 4, first feedback tap index (1-based, sreg[WIDTH] side).
- TAP_B, 3, second feedback tap index.
- LOCK_COUNT, 8, consecutive correct predictions needed to lock (>=1).
- UNLOCK_ERRS, 3, consecutive mismatches while locked that force loss of lock (>=1).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_valid  in  1  bit_in is sampled this cycle.
- bit_in  in  1  received serial bit (generator's newly produced feedback bit each step).
- clear_count  in  1  synchronous clear of err_count.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle strobe, mismatch detected while locked.
- err_count  out  CNT_W  saturating count of mismatches while locked.
- sreg_out  out  WIDTH  local shift register, for debug.

Behaviour:
- Reset (rst=1 at an edge): state=HUNT, sreg=0, fill/good/bad counters=0, locked=0, err_pulse=0, err_count=0. Reset has priority over all inputs, including mid-lock.
- Nothing changes on cycles with bit_valid=0, except:
  - err_pulse returns to 0.
  - clear_count still acts.
- Shift rule: on every valid bit, in every state, sreg <= {sreg[WIDTH-1:1], bit_in}.
- Prediction: pred = sreg[TAP_A] ^ sreg[TAP_B], using the pre-shift register. mismatch = bit_in != pred.
- HUNT:
  - Count valid bits in fill. No comparison is made.
  - After WIDTH valid bits, go to CHECK with good=0.
- CHECK:
  - If pre-shift sreg==0, good=0. The all-zero lockup state is never accepted.
  - Else, on mismatch, good=0.
  - Else good++. When good reaches LOCK_COUNT, go to LOCKED with bad=0.
- LOCKED:
  - On mismatch, or when pre-shift sreg==0, it is an error:
    - err_pulse=1 on the next cycle;
    - err_count += 1, saturating at 2^CNT_W-1;
    - bad++.
  - On a correct bit, bad=0.
  - When bad reaches UNLOCK_ERRS, go to HUNT with fill=0. The error that causes unlock is still counted.
- locked = (state==LOCKED), registered.
  - It rises the cycle after the edge on which the LOCK_COUNT-th good bit is sampled.
  - It falls the cycle after the edge on which the UNLOCK_ERRS-th error is sampled.
- Latency: err_pulse and err_count update are visible 1 cycle after the sampled bit.
- Error multiplication is inherent to self-synchronisation and is required behaviour, not a bug. With default taps, one flipped bit k while locked yields exactly 3 errors: at bits k, k+3 and k+4.
- clear_count together with a counted error in the same cycle: clear wins, err_count=0.
- No errors are counted in HUNT or CHECK.

Decomposition:
- Package lfsr_pkg holds:
  - the state enum {HUNT, CHECK, LOCKED};
  - default WIDTH/TAP constants, shared with the generator;
  - function lfsr_next_bit(sreg, tap_a, tap_b).
- Natural sub-module: lfsr_sat_counter, a CNT_W saturating counter with inc/clear, for err_count.

Test Plan:
Reference stream from seed 0001 is 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1, period 15.
- Acquire lock: rst, then drive the stream with bit_valid=1 every cycle -> locked=0 through bit 11; locked=1 the cycle after bit 12 (4 fill + 8 good); err_count=0.
- Single bit flip: after lock, invert bit k -> err_pulse high on 3 cycles (after k, k+3, k+4); err_count=3; locked stays 1.
- Loss of lock: after lock, drive constant 1s -> err_pulse on 3 consecutive cycles; locked=0 after the 3rd; err_count=3; state HUNT.
- All-zero input: drive 40 zeros after reset -> locked never asserts, err_count=0.
- Gapped valid plus clear: lock using bit_valid toggling 1/0 -> same lock point counted in valid bits. Inject one flip, then pulse clear_count -> err_count=0 the next cycle.
- Reset mid-lock: assert rst while locked -> the next cycle shows locked=0, err_count=0, sreg_out=0; re-lock occurs after 12 more valid bits.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, default polynomial taps
// (x^4+x^3+1) and the feedback-bit helper used by generator and checker.
package lfsr_pkg;
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} lfsr_state_e;

  localparam int LFSR_WIDTH = 4;
  localparam int LFSR_TAP_A = 4;
  localparam int LFSR_TAP_B = 3;

  // Taps are 1-based; bit 0 of sreg holds tap position 1.
  function automatic logic lfsr_next_bit(input logic [31:0] sreg, input int tap_a, input int tap_b);
    logic [4:0] ia;
    logic [4:0] ib;
    ia = 5'(tap_a - 1);
    ib = 5'(tap_b - 1);
    return sreg[ia] ^ sreg[ib];
  endfunction
endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module lfsr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_count <= '0;
    else if (i_inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the Fibonacci LFSR pattern stream:
// hunts, verifies LOCK_COUNT predictions, then counts errors while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH       = LFSR_WIDTH,
  parameter int TAP_A       = LFSR_TAP_A,
  parameter int TAP_B       = LFSR_TAP_B,
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] sreg_out
);
  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  lfsr_state_e       r_state, w_state_nx;
  logic [WIDTH:1]    r_sreg;
  logic [FILL_W-1:0] r_fill, w_fill_nx;
  logic [GOOD_W-1:0] r_good, w_good_nx;
  logic [BAD_W-1:0]  r_bad,  w_bad_nx;
  logic              r_err_pulse;
  logic              w_pred, w_zero, w_mis, w_err;

  assign w_pred = lfsr_next_bit(32'(r_sreg), TAP_A, TAP_B);
  assign w_zero = (r_sreg == '0);
  assign w_mis  = (bit_in != w_pred);
  // An all-zero register is the lockup state, so it counts as an error too.
  assign w_err  = bit_valid && (r_state == LOCKED) && (w_mis || w_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_sreg      <= '0;
      r_fill      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_fill      <= w_fill_nx;
      r_good      <= w_good_nx;
      r_bad       <= w_bad_nx;
      r_err_pulse <= w_err;
      if (bit_valid)
        r_sreg <= {r_sreg[WIDTH-1:1], bit_in};
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_fill_nx  = r_fill;
    w_good_nx  = r_good;
    w_bad_nx   = r_bad;
    if (bit_valid) begin
      case (r_state)
        HUNT: begin
          w_fill_nx = r_fill + 1'b1;
          if (r_fill == FILL_W'(WIDTH - 1)) begin
            w_state_nx = CHECK;
            w_good_nx  = '0;
          end
        end
        CHECK: begin
          if (w_zero || w_mis)
            w_good_nx = '0;
          else if (r_good == GOOD_W'(LOCK_COUNT - 1)) begin
            w_state_nx = LOCKED;
            w_bad_nx   = '0;
          end else
            w_good_nx = r_good + 1'b1;
        end
        LOCKED: begin
          if (w_zero || w_mis) begin
            if (r_bad == BAD_W'(UNLOCK_ERRS - 1)) begin
              w_state_nx = HUNT;
              w_fill_nx  = '0;
            end else
              w_bad_nx = r_bad + 1'b1;
          end else
            w_bad_nx = '0;
        end
        default: w_state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    locked    = (r_state == LOCKED);
    err_pulse = r_err_pulse;
    sreg_out  = r_sreg;
  end

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err),
    .i_clr   (clear_count),
    .o_count (err_count)
  );
endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker against a bit-history reference model,
// plus directed acquisition, flip, unlock, zero-input, gapped and reset cases.
module tb_lfsr_checker;
  localparam int WIDTH = 4, TAP_A = 4, TAP_B = 3, LOCK_COUNT = 8, UNLOCK_ERRS = 3, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, bit_valid, bit_in, clear_count;
  logic             locked, err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] sreg_out;

  lfsr_checker #(.WIDTH(WIDTH), .TAP_A(TAP_A), .TAP_B(TAP_B), .LOCK_COUNT(LOCK_COUNT),
                 .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear_count(clear_count),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .sreg_out(sreg_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int obs_pulses;
  bit any_lock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference stream from seed 0001, period 15.
  bit stream [15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
  int ph = 0;
  function automatic bit nxt();
    bit b;
    b = stream[ph];
    ph = (ph + 1) % 15;
    return b;
  endfunction

  // Model: mode 0=hunting, 1=verifying, 2=locked; history holds last WIDTH bits, oldest first.
  int m_mode, m_fill, m_good, m_bad, m_cnt;
  bit m_pulse;
  bit hist[$];

  task automatic mdl(input bit r, input bit v, input bit b, input bit c);
    bit err, pred, zero;
    if (r) begin
      m_mode = 0; m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_pulse = 0;
      hist = {};
      for (int i = 0; i < WIDTH; i++) hist.push_back(1'b0);
      return;
    end
    err = 0;
    if (v) begin
      pred = hist[WIDTH - TAP_A] ^ hist[WIDTH - TAP_B];
      zero = 1;
      foreach (hist[i]) if (hist[i]) zero = 0;
      if (m_mode == 0) begin
        m_fill++;
        if (m_fill == WIDTH) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (zero || b != pred) m_good = 0;
        else begin
          m_good++;
          if (m_good == LOCK_COUNT) begin m_mode = 2; m_bad = 0; end
        end
      end else begin
        if (zero || b != pred) begin
          err = 1;
          m_bad++;
          if (m_bad == UNLOCK_ERRS) begin m_mode = 0; m_fill = 0; end
        end else m_bad = 0;
      end
      hist.push_back(b);
      void'(hist.pop_front());
    end
    if (c) m_cnt = 0;
    else if (err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    m_pulse = err;
  endtask

  function automatic int exp_sreg();
    int s = 0;
    foreach (hist[i]) s = (s << 1) | int'(hist[i]);
    return s;
  endfunction

  task automatic step(input bit r, input bit v, input bit b, input bit c);
    rst = r; bit_valid = v; bit_in = b; clear_count = c;
    @(posedge clk);
    mdl(r, v, b, c);
    #1;
    chk("locked", int'(locked), int'(m_mode == 2));
    chk("err_pulse", int'(err_pulse), int'(m_pulse));
    chk("err_count", int'(err_count), m_cnt);
    chk("sreg_out", int'(sreg_out), exp_sreg());
    if (err_pulse) obs_pulses++;
    if (locked) any_lock = 1;
  endtask

  task automatic good_bits(input int n);
    for (int i = 0; i < n; i++) step(0, 1, nxt(), 0);
  endtask

  initial begin
    rst = 1; bit_valid = 0; bit_in = 0; clear_count = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_cnt", int'(err_count), 0);
    chk("rst_sreg", int'(sreg_out), 0);

    // Acquire: 4 fill + 8 good bits.
    ph = 0;
    good_bits(11);
    chk("acq_bit11", int'(locked), 0);
    good_bits(1);
    chk("acq_bit12", int'(locked), 1);
    chk("acq_cnt", int'(err_count), 0);

    // Single flip yields exactly three errors.
    good_bits(3);
    obs_pulses = 0;
    step(0, 1, ~nxt(), 0);
    good_bits(10);
    chk("flip_pulses", obs_pulses, 3);
    chk("flip_cnt", int'(err_count), 3);
    chk("flip_locked", int'(locked), 1);

    // Constant ones force loss of lock.
    step(0, 0, 0, 1);
    chk("clr_idle", int'(err_count), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
    chk("loss_locked", int'(locked), 0);

    // All-zero input never locks.
    step(1, 0, 0, 0);
    any_lock = 0;
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
    chk("zero_nolock", int'(any_lock), 0);
    chk("zero_cnt", int'(err_count), 0);

    // Gapped valid: lock point counted in valid bits, then flip and clear.
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, nxt(), 0);
      if (i == 10) chk("gap_bit11", int'(locked), 0);
      step(0, 0, 1, 0);
    end
    chk("gap_lock", int'(locked), 1);
    step(0, 1, ~nxt(), 0);
    for (int i = 0; i < 6; i++) begin step(0, 0, 0, 0); step(0, 1, nxt(), 0); end
    chk("gap_cnt", int'(err_count), 3);
    step(0, 0, 0, 1);
    chk("gap_clr", int'(err_count), 0);

    // Reset mid-lock, then relock after 12 valid bits.
    step(1, 1, nxt(), 0);
    chk("mid_locked", int'(locked), 0);
    chk("mid_cnt", int'(err_count), 0);
    chk("mid_sreg", int'(sreg_out), 0);
    good_bits(11);
    chk("relock_11", int'(locked), 0);
    good_bits(1);
    chk("relock_12", int'(locked), 1);

    // Randomized traffic: gaps, flips, error bursts, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, v, b, c;
      r = ($urandom % 250) == 0;
      v = ($urandom % 4) != 0;
      c = ($urandom % 60) == 0;
      b = ($urandom % 2) == 1;
      if (v && ($urandom % 100) >= 3) b = nxt() ^ (($urandom % 30) == 0);
      step(r, v, b, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
